fifo_wconv: RTL and testbench

- Parametrised width-converting bit-stream FIFO.
- Accepts W_IN-bit words on the write side and delivers W_OUT-bit chunks on the read side. W_IN and W_OUT are arbitrary; a read chunk may span stored entries and wrap around the buffer.
- Generalises the fixed 8-in/3-out, 16-deep lab FIFO. Adds an exposed fill level, a programmable almost-full threshold, registered read-valid, underflow reporting and data hold when idle.
- Single clock domain; sits between a byte-oriented producer and a narrow-symbol consumer.

---
 rtl/fifo_wconv.sv | 123 ++++++++++++
 tb/tb_fifo_wconv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wconv.sv
// rtl/fifo_wconv.sv - width-converting bit-stream FIFO (W_IN-bit words in, W_OUT-bit chunks out)
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   w_en, data_w          write request and word (bit 0 leaves first)
//   r_en                  read request
//   data_r, r_valid       registered read chunk (bit 0 oldest) and its valid strobe
//   level                 number of stored bits
//   full, empty           no room for a word / no complete chunk
//   half_full             level >= CAP/2
//   almost_full           level >= AF_THRESH
//   overflow, underflow   one-cycle pulses for rejected write / rejected read
module fifo_wconv #(
    parameter int W_IN      = 8,
    parameter int W_OUT     = 3,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 96,
    localparam int CAP      = W_IN * DEPTH,
    localparam int LW       = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic [W_IN-1:0]  data_w,
    input  logic             r_en,
    output logic [W_OUT-1:0] data_r,
    output logic             r_valid,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);
    // Bit-pointer width; one extra bit is kept while adding so the wrap
    // can be done by subtracting CAP (CAP need not be a power of two).
    localparam int PW = $clog2(CAP);

    localparam logic [PW:0]   CAP_P   = (PW+1)'(CAP);
    localparam logic [PW:0]   W_IN_P  = (PW+1)'(W_IN);
    localparam logic [PW:0]   W_OUT_P = (PW+1)'(W_OUT);
    localparam logic [LW:0]   W_IN_L  = (LW+1)'(W_IN);
    localparam logic [LW:0]   W_OUT_L = (LW+1)'(W_OUT);
    localparam logic [LW-1:0] FULL_GT = LW'(CAP - W_IN);
    localparam logic [LW-1:0] CHUNK_B = LW'(W_OUT);
    localparam logic [LW-1:0] HALF_B  = LW'(CAP / 2);
    localparam logic [LW-1:0] AF_B    = LW'(AF_THRESH);

    logic [CAP-1:0]   mem_q;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [W_OUT-1:0] data_r_q, chunk;
    logic             r_valid_q, overflow_q, underflow_q;
    logic             w_acc, r_acc;

    // Advance a bit pointer by step (< CAP) modulo CAP.
    function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [PW:0] step);
        logic [PW:0] s;
        s = {1'b0, p} + step;
        if (s >= CAP_P) begin
            s = s - CAP_P;
        end
        return s[PW-1:0];
    endfunction

    assign full        = level_q > FULL_GT;
    assign empty       = level_q < CHUNK_B;
    assign half_full   = level_q >= HALF_B;
    assign almost_full = level_q >= AF_B;

    // Both sides are judged against the pre-edge level, so a write at full
    // stays rejected even when a read frees space in the same cycle.
    assign w_acc = w_en && !full;
    assign r_acc = r_en && !empty;

    always_comb begin
        wptr_d  = w_acc ? adv(wptr_q, W_IN_P) : wptr_q;
        rptr_d  = r_acc ? adv(rptr_q, W_OUT_P) : rptr_q;
        level_d = LW'({1'b0, level_q} + (w_acc ? W_IN_L : '0) - (r_acc ? W_OUT_L : '0));
        chunk   = '0;
        // A chunk may straddle entries and the end of the buffer.
        for (int i = 0; i < W_OUT; i++) begin
            chunk[i] = mem_q[adv(rptr_q, (PW+1)'(i))];
        end
    end

    // Storage is deliberately not reset; level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem_q[wptr_q +: W_IN] <= data_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            data_r_q    <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            r_valid_q   <= r_acc;
            overflow_q  <= w_en && full;
            underflow_q <= r_en && empty;
            if (r_acc) begin
                data_r_q <= chunk;
            end
        end
    end

    assign data_r    = data_r_q;
    assign r_valid   = r_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_fifo_wconv.sv
// tb/tb_fifo_wconv.sv - self-checking bench for fifo_wconv against a bit-queue model
module tb_fifo_wconv;
    localparam int W_IN      = 8;
    localparam int W_OUT     = 3;
    localparam int DEPTH     = 16;
    localparam int AF_THRESH = 96;
    localparam int CAP       = W_IN * DEPTH;
    localparam int LW        = $clog2(CAP + 1);

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             w_en   = 1'b0;
    logic             r_en   = 1'b0;
    logic [W_IN-1:0]  data_w = '0;
    logic [W_OUT-1:0] data_r;
    logic             r_valid;
    logic [LW-1:0]    level;
    logic             full, empty, half_full, almost_full, overflow, underflow;

    int tests = 0;
    int fails = 0;

    // Reference model: the stored stream as a plain queue of bits.
    bit               model_q[$];
    logic [W_OUT-1:0] exp_data = '0;
    int               bits_read = 0;

    fifo_wconv #(
        .W_IN(W_IN), .W_OUT(W_OUT), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_w(data_w), .r_en(r_en),
        .data_r(data_r), .r_valid(r_valid), .level(level), .full(full),
        .empty(empty), .half_full(half_full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int lvl;
        lvl = model_q.size();
        check({tag, "_level"}, 32'(level), lvl);
        check({tag, "_full"}, 32'(full), 32'(lvl > CAP - W_IN));
        check({tag, "_empty"}, 32'(empty), 32'(lvl < W_OUT));
        check({tag, "_half"}, 32'(half_full), 32'(lvl >= CAP / 2));
        check({tag, "_afull"}, 32'(almost_full), 32'(lvl >= AF_THRESH));
    endtask

    // One clock cycle of stimulus; model updated from the rules, then DUT checked.
    task automatic cycle(input logic we, input logic [W_IN-1:0] wd, input logic re);
        int lvl;
        bit wacc, racc, exp_ovf, exp_unf;
        lvl     = model_q.size();
        exp_ovf = we && (lvl > CAP - W_IN);
        exp_unf = re && (lvl < W_OUT);
        wacc    = we && !exp_ovf;
        racc    = re && !exp_unf;
        w_en    = we;
        data_w  = wd;
        r_en    = re;
        if (racc) begin
            for (int i = 0; i < W_OUT; i++) exp_data[i] = model_q.pop_front();
            bits_read += W_OUT;
        end
        if (wacc) begin
            for (int i = 0; i < W_IN; i++) model_q.push_back(wd[i]);
        end
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check("r_valid", 32'(r_valid), 32'(racc));
        check("data_r", 32'(data_r), 32'(exp_data));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
        check_status("cyc");
    endtask

    task automatic do_reset();
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_q.delete();
        exp_data = '0;
        #1;
        check("rst_data_r", 32'(data_r), 0);
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);
        check_status("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W_OUT-1:0] seq1 [8];
        seq1 = '{3'd5, 3'd6, 3'd2, 3'd6, 3'd3, 3'd4, 3'd5, 3'd4};

        // Reset state
        do_reset();

        // Ordering across entries
        cycle(1'b1, 8'hB5, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h96, 1'b0);
        check("t1_level24", 32'(level), 24);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("t1_seq", 32'(data_r), 32'(seq1[i]));
        end
        check("t1_empty", 32'(empty), 1);
        check("t1_level0", 32'(level), 0);

        // Underflow with residual bits
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t2_level2", 32'(level), 2);
        cycle(1'b0, '0, 1'b1);
        check("t2_unf", 32'(underflow), 1);
        check("t2_hold", 32'(data_r), 7);
        check("t2_rvalid", 32'(r_valid), 0);
        cycle(1'b0, '0, 1'b0);
        check("t2_unf_pulse", 32'(underflow), 0);
        check("t2_level_hold", 32'(level), 2);

        // Fill flags, overflow, full readout
        do_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(1'b1, W_IN'($urandom), 1'b0);
            check("t3_half", 32'(half_full), 32'(k >= 8));
            check("t3_afull", 32'(almost_full), 32'(k >= 12));
            check("t3_full", 32'(full), 32'(k == DEPTH));
        end
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0);
        check("t3_ovf_repeat", 32'(overflow), 1);
        check("t3_level128", 32'(level), CAP);
        while (model_q.size() >= W_OUT) cycle(1'b0, '0, 1'b1);

        // Simultaneous access
        do_reset();
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b1, 8'h81, 1'b1);
        check("t4_level13", 32'(level), 13);
        do_reset();
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, W_IN'($urandom), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        check("t4_level125", 32'(level), CAP - W_OUT);
        check("t4_ovf", 32'(overflow), 1);

        // Wrap-around soak
        do_reset();
        bits_read = 0;
        for (int n = 0; n < 6000 && bits_read < 4 * CAP; n++) begin
            int wp;
            wp = ((n / 60) % 2 == 0) ? 75 : 20;
            cycle($urandom_range(0, 99) < wp, W_IN'($urandom), $urandom_range(0, 99) < 50);
        end
        check("t5_throughput", 32'(bits_read >= 3 * CAP), 1);

        // Reset mid-stream at level 50
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, W_IN'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t6_level50", 32'(level), 50);
        @(negedge clk);
        rst_n = 1'b0;
        model_q.delete();
        exp_data = '0;
        #1;
        check("t6_async_level", 32'(level), 0);
        check("t6_async_empty", 32'(empty), 1);
        check("t6_async_data", 32'(data_r), 0);
        check("t6_async_rvalid", 32'(r_valid), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h07, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("t6_read7", 32'(data_r), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
